// File: rtl/mem_readback_scanner.sv
// Read-back scanner: walks a registered-output RAM from address 0 to DEPTH_MEM-1 and streams
// each word with its address through a 4-entry FIFO while accumulating a running checksum.
module mem_readback_scanner #(
   parameter int unsigned WID_MEM   = 18,
   parameter int unsigned DEPTH_MEM = 4096,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned CSUM_W    = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   output logic [ADDR_W-1:0]  o_raddr,
   input  logic [WID_MEM-1:0] i_rdata,
   output logic [WID_MEM-1:0] o_m_data,
   output logic [ADDR_W-1:0]  o_m_addr,
   output logic               o_m_valid,
   input  logic               i_m_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic [CSUM_W-1:0]  o_checksum
);

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_MEM - 1);

   state_e             r_state, w_state_next;
   logic [ADDR_W-1:0]  r_raddr, r_a2, w_raddr_inc;
   logic               r_v1, r_v2;
   logic [WID_MEM-1:0] r_fdata [4];
   logic [ADDR_W-1:0]  r_faddr [4];
   logic [1:0]         r_wptr, r_rptr;
   logic [2:0]         r_fill;
   logic [3:0]         w_occupancy;
   logic [CSUM_W-1:0]  r_csum;
   logic               w_start_ok, w_issue, w_push, w_pop;

   assign w_raddr_inc = r_raddr + ADDR_W'(1);
   // Stored words plus reads still inside the memory pipeline; bounding this at 4 means a
   // capture always finds a free FIFO slot.
   assign w_occupancy = 4'(r_fill) + 4'(r_v1) + 4'(r_v2);
   assign w_push      = r_v2;
   assign w_pop       = o_m_valid && i_m_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start_ok   = 1'b0;
      w_issue      = 1'b0;
      unique case (r_state)
         StIdle, StDone: begin
            if (i_start) begin
               w_start_ok   = 1'b1;
               w_state_next = StScan;
            end
         end
         StScan: begin
            if (r_raddr == LastAddr) begin
               w_state_next = StDrain;
            end else if (w_occupancy < 4'd4) begin
               w_issue = 1'b1;
               if (w_raddr_inc == LastAddr) begin
                  w_state_next = StDrain;
               end
            end
         end
         StDrain: begin
            if ((r_fill == 3'd0) && !r_v1 && !r_v2) begin
               w_state_next = StDone;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_raddr <= '0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_a2    <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_fill  <= '0;
         r_csum  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_fdata[i] <= '0;
            r_faddr[i] <= '0;
         end
      end else begin
         // r_v1 marks the address now on raddr; r_v2 marks the cycle its rdata is valid.
         if (w_start_ok) begin
            r_raddr <= '0;
            r_v1    <= 1'b1;
         end else if (w_issue) begin
            r_raddr <= w_raddr_inc;
            r_v1    <= 1'b1;
         end else begin
            r_v1 <= 1'b0;
         end
         r_v2 <= r_v1;
         r_a2 <= r_raddr;

         if (w_push) begin
            r_fdata[r_wptr] <= i_rdata;
            r_faddr[r_wptr] <= r_a2;
            r_wptr          <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 2'd1;
         end
         if (w_push && !w_pop) begin
            r_fill <= r_fill + 3'd1;
         end else if (!w_push && w_pop) begin
            r_fill <= r_fill - 3'd1;
         end

         if (w_start_ok) begin
            r_csum <= '0;
         end else if (w_pop) begin
            r_csum <= r_csum + CSUM_W'(o_m_data);
         end
      end
   end

   assign o_raddr    = r_raddr;
   assign o_m_valid  = (r_fill != 3'd0);
   assign o_m_data   = r_fdata[r_rptr];
   assign o_m_addr   = r_faddr[r_rptr];
   assign o_busy     = (r_state == StScan) || (r_state == StDrain);
   assign o_done     = (r_state == StDone);
   assign o_checksum = r_csum;

endmodule

// File: tb/tb_mem_readback_scanner.sv
// Bench for mem_readback_scanner: a registered-output RAM model feeds the scanner; beats are
// recorded and compared against the RAM contents and an arithmetic checksum model.
module tb_mem_readback_scanner;

   localparam int WID   = 18;
   localparam int DEPTH = 4096;
   localparam int AW    = 12;
   localparam int CW    = 32;

   logic           clk = 1'b0;
   logic           reset, start, m_ready;
   logic [AW-1:0]  raddr, m_addr;
   logic [WID-1:0] rdata, m_data;
   logic           m_valid, busy, done;
   logic [CW-1:0]  checksum;

   logic [WID-1:0] ram [DEPTH];

   always #5 clk = ~clk;

   always @(posedge clk) rdata <= ram[raddr];

   mem_readback_scanner #(
      .WID_MEM  (WID),
      .DEPTH_MEM(DEPTH),
      .ADDR_W   (AW),
      .CSUM_W   (CW)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_start   (start),
      .o_raddr   (raddr),
      .i_rdata   (rdata),
      .o_m_data  (m_data),
      .o_m_addr  (m_addr),
      .o_m_valid (m_valid),
      .i_m_ready (m_ready),
      .o_busy    (busy),
      .o_done    (done),
      .o_checksum(checksum)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int start_cyc, first_valid_cyc, stall_viol, max_raddr;
   bit             prev_stall;
   logic [WID-1:0] prev_data;
   logic [AW-1:0]  prev_addr;
   logic [WID-1:0] q_data [$];
   logic [AW-1:0]  q_addr [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Beat recorder and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (first_valid_cyc < 0 && m_valid === 1'b1) first_valid_cyc = cyc;
      if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_addr !== prev_addr))
         stall_viol++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
         q_data.push_back(m_data);
         q_addr.push_back(m_addr);
      end
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data  = m_data;
      prev_addr  = m_addr;
   end

   function automatic logic [CW-1:0] model_csum();
      longint s = 0;
      for (int i = 0; i < DEPTH; i++) s += longint'(ram[i]);
      return CW'(s);
   endfunction

   // Expected stream is simply ram[0..DEPTH-1] in address order.
   function automatic int bad_beats();
      int bad = 0;
      for (int i = 0; i < q_data.size(); i++)
         if (q_addr[i] !== AW'(i) || q_data[i] !== ram[i]) bad++;
      return bad;
   endfunction

   task automatic clear_mon();
      q_data.delete();
      q_addr.delete();
      first_valid_cyc = -1;
      stall_viol      = 0;
      prev_stall      = 1'b0;
      max_raddr       = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
      clear_mon();
   endtask

   task automatic wait_done(input int budget, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (rnd) m_ready = 1'($urandom_range(0, 1));
      end
      m_ready = 1'b1;
   endtask

   task automatic wait_beats(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (q_data.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (raddr !== '0) $display("FAIL rst_raddr got %0h want 0", raddr); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== '0) $display("FAIL rst_data got %0h want 0", m_data); else n_pass++;
      n_checks++; if (m_addr !== '0) $display("FAIL rst_addr got %0h want 0", m_addr); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %0b want 0", done); else n_pass++;
      n_checks++; if (checksum !== '0) $display("FAIL rst_csum got %0h want 0", checksum); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_full_scan();
      bit ok;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
      m_ready = 1'b1;
      pulse_start();
      wait_done(5000, 1'b0, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL full_timeout got %0b want 1", ok); else n_pass++;
      n_checks++; if (first_valid_cyc - start_cyc !== 2)
         $display("FAIL full_first_valid got %0d want 2", first_valid_cyc - start_cyc); else n_pass++;
      n_checks++; if (cyc - start_cyc !== 4099)
         $display("FAIL full_done_latency got %0d want 4099", cyc - start_cyc); else n_pass++;
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL full_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL full_order got %0d bad want 0", bad_beats()); else n_pass++;
      n_checks++; if (checksum !== 32'h007F_F800)
         $display("FAIL full_csum got %0h want 7ff800", checksum); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL full_busy got %0b want 0", busy); else n_pass++;
   endtask

   task automatic test_random_ready();
      bit ok;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
      pulse_start();
      wait_done(20000, 1'b1, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL rr_timeout got %0b want 1", ok); else n_pass++;
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL rr_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL rr_order got %0d bad want 0", bad_beats()); else n_pass++;
      n_checks++; if (stall_viol !== 0) $display("FAIL rr_stall got %0d want 0", stall_viol); else n_pass++;
      n_checks++; if (checksum !== 32'h007F_F800)
         $display("FAIL rr_csum got %0h want 7ff800", checksum); else n_pass++;
   endtask

   task automatic test_random_data();
      bit ok;
      logic [CW-1:0] exp;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
      exp = model_csum();
      pulse_start();
      wait_done(20000, 1'b1, ok);
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL rd_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL rd_order got %0d bad want 0", bad_beats()); else n_pass++;
      n_checks++; if (stall_viol !== 0) $display("FAIL rd_stall got %0d want 0", stall_viol); else n_pass++;
      n_checks++; if (checksum !== exp) $display("FAIL rd_csum got %0h want %0h", checksum, exp); else n_pass++;
   endtask

   task automatic test_stall();
      bit ok;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
      m_ready = 1'b0;
      pulse_start();
      repeat (100) @(posedge clk);
      #1;
      n_checks++; if (max_raddr > 3) $display("FAIL stall_raddr got %0d want <=3", max_raddr); else n_pass++;
      n_checks++; if (m_valid !== 1'b1) $display("FAIL stall_valid got %0b want 1", m_valid); else n_pass++;
      n_checks++; if (m_addr !== '0) $display("FAIL stall_addr got %0h want 0", m_addr); else n_pass++;
      n_checks++; if (stall_viol !== 0) $display("FAIL stall_stable got %0d want 0", stall_viol); else n_pass++;
      m_ready = 1'b1;
      wait_done(5000, 1'b0, ok);
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL stall_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL stall_order got %0d bad want 0", bad_beats()); else n_pass++;
      n_checks++; if (checksum !== 32'h007F_F800)
         $display("FAIL stall_csum got %0h want 7ff800", checksum); else n_pass++;
   endtask

   task automatic test_all_ones();
      bit ok;
      logic [CW-1:0] exp;
      for (int i = 0; i < DEPTH; i++) ram[i] = 18'h3FFFF;
      exp = model_csum();
      pulse_start();
      wait_done(5000, 1'b0, ok);
      n_checks++; if (checksum !== 32'h3FFF_F000)
         $display("FAIL ones_csum got %0h want 3ffff000", checksum); else n_pass++;
      n_checks++; if (checksum !== exp) $display("FAIL ones_model got %0h want %0h", checksum, exp); else n_pass++;
   endtask

   task automatic test_reset_mid_scan();
      bit ok;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
      pulse_start();
      wait_beats(1000, 2000, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL mid_reach got %0b want 1", ok); else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (raddr !== '0) $display("FAIL mid_raddr got %0h want 0", raddr); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== '0) $display("FAIL mid_data got %0h want 0", m_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %0b want 0", busy); else n_pass++;
      n_checks++; if (checksum !== '0) $display("FAIL mid_csum got %0h want 0", checksum); else n_pass++;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL mid_inflight got %0b want 0", m_valid); else n_pass++;
      pulse_start();
      wait_done(5000, 1'b0, ok);
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL mid_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL mid_order got %0d bad want 0", bad_beats()); else n_pass++;
      n_checks++; if (checksum !== 32'h007F_F800)
         $display("FAIL mid_rescan_csum got %0h want 7ff800", checksum); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [CW-1:0] exp;
      for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
      exp = model_csum();
      pulse_start();
      wait_beats(500, 1000, ok);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(5000, 1'b0, ok);
      n_checks++; if (cyc - start_cyc !== 4099)
         $display("FAIL busy_start_latency got %0d want 4099", cyc - start_cyc); else n_pass++;
      n_checks++; if (q_data.size() !== DEPTH)
         $display("FAIL busy_start_count got %0d want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (bad_beats() !== 0) $display("FAIL busy_start_order got %0d want 0", bad_beats()); else n_pass++;
      n_checks++; if (checksum !== exp) $display("FAIL busy_start_csum got %0h want %0h", checksum, exp); else n_pass++;
      pulse_start();
      n_checks++; if (done !== 1'b0) $display("FAIL restart_done got %0b want 0", done); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy got %0b want 1", busy); else n_pass++;
      n_checks++; if (checksum !== '0) $display("FAIL restart_csum_clr got %0h want 0", checksum); else n_pass++;
      wait_done(5000, 1'b0, ok);
      n_checks++; if (cyc - start_cyc !== 4099)
         $display("FAIL restart_latency got %0d want 4099", cyc - start_cyc); else n_pass++;
      n_checks++; if (bad_beats() !== 0 || q_data.size() !== DEPTH)
         $display("FAIL restart_beats got %0d beats want %0d", q_data.size(), DEPTH); else n_pass++;
      n_checks++; if (checksum !== exp) $display("FAIL restart_csum got %0h want %0h", checksum, exp); else n_pass++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_mon();
      test_reset();
      test_full_scan();
      test_random_ready();
      test_random_data();
      test_stall();
      test_all_ones();
      test_reset_mid_scan();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
